// File: rtl/csr_access_ctrl_pkg.sv
// Shared constants and encodings for the CSR access sequencer: machine-mode CSR
// addresses, mstatus field positions, sequencer states and CSR funct3 codes.
package csr_access_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS_ADDR = 12'h300;
    localparam logic [11:0] CSR_MTVEC_ADDR   = 12'h305;
    localparam logic [11:0] CSR_MEPC_ADDR    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE_ADDR  = 12'h342;
    localparam logic [11:0] CSR_MTVAL_ADDR   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INST_WR,
        ST_T_EPC,
        ST_T_CAUSE,
        ST_T_TVAL,
        ST_T_STAT,
        ST_T_VEC,
        ST_M_RD,
        ST_M_WR,
        ST_M_VEC
    } state_e;

    typedef enum logic [2:0] {
        F3_CSRRW  = 3'b001,
        F3_CSRRS  = 3'b010,
        F3_CSRRC  = 3'b011,
        F3_CSRRWI = 3'b101,
        F3_CSRRSI = 3'b110,
        F3_CSRRCI = 3'b111
    } funct3_e;

endpackage

// File: rtl/csr_access_ctrl.sv
// Serialises CSR instructions, trap entry and mret onto the single read and
// single write port of the CSR register file, and issues the PC redirect.
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inst_valid_i,
    output logic        inst_ready_o,
    input  logic [2:0]  inst_op_i,
    input  logic [11:0] inst_addr_i,
    input  logic [31:0] inst_src_i,
    input  logic        inst_src_zero_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_illegal_o,
    input  logic        trap_valid_i,
    output logic        trap_ready_o,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic [31:0] trap_tval_i,
    input  logic        mret_valid_i,
    output logic        mret_ready_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic [11:0] csr_r_addr_o,
    input  logic [31:0] csr_r_val_i,
    output logic [11:0] csr_w_addr_o,
    output logic [31:0] csr_w_val_o,
    output logic        csr_w_enable_o
);

    function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [11:0] inst_addr_q;
    logic [31:0] inst_old_q, inst_wdata_q;
    logic        inst_wen_q, inst_illegal_q;
    logic [31:0] trap_cause_q, trap_pc_q, trap_tval_q;
    logic [31:0] mstatus_q;

    logic        idle;
    logic        inst_acc, trap_acc;
    logic        inst_writes, inst_illegal;
    logic [31:0] inst_new;

    assign idle         = (state_q == ST_IDLE);
    assign trap_ready_o = idle;
    assign mret_ready_o = idle & ~trap_valid_i;
    assign inst_ready_o = idle & ~trap_valid_i & ~mret_valid_i;
    assign inst_acc     = inst_valid_i & inst_ready_o;
    assign trap_acc     = trap_valid_i & trap_ready_o;

    // Decode is evaluated in the accept cycle while csr_r_val_i holds the old value.
    always_comb begin
        inst_new    = inst_src_i;
        inst_writes = 1'b0;
        case (inst_op_i)
            F3_CSRRW, F3_CSRRWI: begin
                inst_new    = inst_src_i;
                inst_writes = 1'b1;
            end
            F3_CSRRS, F3_CSRRSI: begin
                inst_new    = csr_r_val_i | inst_src_i;
                inst_writes = ~inst_src_zero_i;
            end
            F3_CSRRC, F3_CSRRCI: begin
                inst_new    = csr_r_val_i & ~inst_src_i;
                inst_writes = ~inst_src_zero_i;
            end
            default: ;
        endcase
        inst_illegal = (inst_op_i[1:0] == 2'b00)
                     | (inst_writes & (inst_addr_i[11:10] == 2'b11));
    end

    always_comb begin
        state_d          = state_q;
        csr_r_addr_o     = 12'h000;
        csr_w_enable_o   = 1'b0;
        csr_w_addr_o     = 12'h000;
        csr_w_val_o      = 32'h0;
        rsp_valid_o      = 1'b0;
        rsp_rdata_o      = 32'h0;
        rsp_illegal_o    = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (trap_valid_i) begin
                    state_d = ST_T_EPC;
                end else if (mret_valid_i) begin
                    state_d = ST_M_RD;
                end else if (inst_valid_i) begin
                    state_d      = ST_INST_WR;
                    csr_r_addr_o = inst_addr_i;
                end
            end
            ST_INST_WR: begin
                state_d        = ST_IDLE;
                csr_w_enable_o = inst_wen_q;
                csr_w_addr_o   = inst_addr_q;
                csr_w_val_o    = inst_wdata_q;
                rsp_valid_o    = 1'b1;
                rsp_rdata_o    = inst_illegal_q ? 32'h0 : inst_old_q;
                rsp_illegal_o  = inst_illegal_q;
            end
            ST_T_EPC: begin
                state_d        = ST_T_CAUSE;
                csr_r_addr_o   = CSR_MSTATUS_ADDR;
                csr_w_enable_o = 1'b1;
                csr_w_addr_o   = CSR_MEPC_ADDR;
                csr_w_val_o    = trap_pc_q & ~32'h3;
            end
            ST_T_CAUSE: begin
                state_d        = ST_T_TVAL;
                csr_w_enable_o = 1'b1;
                csr_w_addr_o   = CSR_MCAUSE_ADDR;
                csr_w_val_o    = trap_cause_q;
            end
            ST_T_TVAL: begin
                state_d        = ST_T_STAT;
                csr_w_enable_o = 1'b1;
                csr_w_addr_o   = CSR_MTVAL_ADDR;
                csr_w_val_o    = trap_tval_q;
            end
            ST_T_STAT: begin
                state_d        = ST_T_VEC;
                csr_w_enable_o = 1'b1;
                csr_w_addr_o   = CSR_MSTATUS_ADDR;
                csr_w_val_o    = trap_mstatus(mstatus_q);
            end
            ST_T_VEC: begin
                // Direct mode only: the mode bits of mtvec are dropped.
                state_d          = ST_IDLE;
                csr_r_addr_o     = CSR_MTVEC_ADDR;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = csr_r_val_i & ~32'h3;
            end
            ST_M_RD: begin
                state_d      = ST_M_WR;
                csr_r_addr_o = CSR_MSTATUS_ADDR;
            end
            ST_M_WR: begin
                state_d        = ST_M_VEC;
                csr_w_enable_o = 1'b1;
                csr_w_addr_o   = CSR_MSTATUS_ADDR;
                csr_w_val_o    = mret_mstatus(mstatus_q);
            end
            ST_M_VEC: begin
                state_d          = ST_IDLE;
                csr_r_addr_o     = CSR_MEPC_ADDR;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = csr_r_val_i;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            inst_addr_q    <= 12'h000;
            inst_old_q     <= 32'h0;
            inst_wdata_q   <= 32'h0;
            inst_wen_q     <= 1'b0;
            inst_illegal_q <= 1'b0;
            trap_cause_q   <= 32'h0;
            trap_pc_q      <= 32'h0;
            trap_tval_q    <= 32'h0;
            mstatus_q      <= 32'h0;
        end else begin
            state_q <= state_d;
            if (inst_acc) begin
                inst_addr_q    <= inst_addr_i;
                inst_old_q     <= csr_r_val_i;
                inst_wdata_q   <= inst_new;
                inst_wen_q     <= inst_writes & ~inst_illegal;
                inst_illegal_q <= inst_illegal;
            end
            if (trap_acc) begin
                trap_cause_q <= trap_cause_i;
                trap_pc_q    <= trap_pc_i;
                trap_tval_q  <= trap_tval_i;
            end
            if (state_q == ST_T_EPC || state_q == ST_M_RD) begin
                mstatus_q <= csr_r_val_i;
            end
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: a behavioural regfile on the CSR ports, directed
// scenarios plus random instruction/trap/mret traffic against a spec-level model.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, inst_ready, inst_src_zero;
    logic [2:0]  inst_op;
    logic [11:0] inst_addr;
    logic [31:0] inst_src;
    logic        rsp_valid, rsp_illegal;
    logic [31:0] rsp_rdata;
    logic        trap_valid, trap_ready;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic        mret_valid, mret_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] csr_r_addr, csr_w_addr;
    logic [31:0] csr_r_val, csr_w_val;
    logic        csr_w_enable;

    logic [31:0] regs  [0:4095];
    logic [31:0] model [0:4095];
    logic        mem_clr, preset_en;
    logic [11:0] preset_addr;
    logic [31:0] preset_val;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    csr_access_ctrl dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .inst_valid_i     (inst_valid),
        .inst_ready_o     (inst_ready),
        .inst_op_i        (inst_op),
        .inst_addr_i      (inst_addr),
        .inst_src_i       (inst_src),
        .inst_src_zero_i  (inst_src_zero),
        .rsp_valid_o      (rsp_valid),
        .rsp_rdata_o      (rsp_rdata),
        .rsp_illegal_o    (rsp_illegal),
        .trap_valid_i     (trap_valid),
        .trap_ready_o     (trap_ready),
        .trap_cause_i     (trap_cause),
        .trap_pc_i        (trap_pc),
        .trap_tval_i      (trap_tval),
        .mret_valid_i     (mret_valid),
        .mret_ready_o     (mret_ready),
        .redirect_valid_o (redirect_valid),
        .redirect_pc_o    (redirect_pc),
        .csr_r_addr_o     (csr_r_addr),
        .csr_r_val_i      (csr_r_val),
        .csr_w_addr_o     (csr_w_addr),
        .csr_w_val_o      (csr_w_val),
        .csr_w_enable_o   (csr_w_enable)
    );

    // Behavioural regfile: combinational read, write on the clock edge.
    assign csr_r_val = regs[csr_r_addr];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) regs[i] <= 32'h0;
        end else begin
            if (csr_w_enable) regs[csr_w_addr] <= csr_w_val;
            if (preset_en)    regs[preset_addr] <= preset_val;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // A write must never target the address being read in the same cycle.
    always @(negedge clk) begin
        if (!rst && csr_w_enable)
            check("wr_rd_same_addr", {31'h0, csr_r_addr == csr_w_addr}, 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [11:0] a, input logic [31:0] v);
        preset_en = 1'b1; preset_addr = a; preset_val = v;
        tick();
        preset_en = 1'b0;
        model[a] = v;
    endtask

    task automatic do_inst(input logic [2:0] op, input logic [11:0] a,
                           input logic [31:0] src, input logic sz);
        logic [31:0] old, nv;
        logic        wr, ill;
        old = model[a];
        case (op)
            3'b001, 3'b101: begin nv = src;        wr = 1'b1; end
            3'b010, 3'b110: begin nv = old | src;  wr = !sz;  end
            3'b011, 3'b111: begin nv = old & ~src; wr = !sz;  end
            default:        begin nv = 32'h0;      wr = 1'b0; end
        endcase
        ill = (op == 3'b000 || op == 3'b100) || (wr && a[11:10] == 2'b11);
        if (ill) wr = 1'b0;
        inst_valid = 1'b1; inst_op = op; inst_addr = a; inst_src = src; inst_src_zero = sz;
        #1;
        check("inst_ready", {31'h0, inst_ready}, 32'h1);
        tick();
        inst_valid = 1'b0;
        check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("rsp_rdata", rsp_rdata, ill ? 32'h0 : old);
        check("rsp_illegal", {31'h0, rsp_illegal}, {31'h0, ill});
        check("inst_w_enable", {31'h0, csr_w_enable}, {31'h0, wr});
        if (wr) begin
            check("inst_w_addr", {20'h0, csr_w_addr}, {20'h0, a});
            check("inst_w_val", csr_w_val, nv);
        end
        tick();
        check("inst_done_rsp", {31'h0, rsp_valid}, 32'h0);
        check("inst_done_wen", {31'h0, csr_w_enable}, 32'h0);
        check("inst_done_idle", {31'h0, trap_ready}, 32'h1);
        if (wr) model[a] = nv;
        $display("inst op=%0d addr=%03h src=%08h zero=%0d -> old=%08h illegal=%0d write=%0d new=%08h",
                 op, a, src, sz, old, ill, wr, nv);
    endtask

    task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval);
        logic [31:0] st, st_new, tv;
        logic [11:0] wa [4];
        logic [31:0] wv [4];
        st = model[12'h300];
        tv = model[12'h305];
        st_new = (st & ~32'h1888) | 32'h1800 | ((st & 32'h8) << 4);
        wa[0] = 12'h341; wv[0] = pc & ~32'h3;
        wa[1] = 12'h342; wv[1] = cause;
        wa[2] = 12'h343; wv[2] = tval;
        wa[3] = 12'h300; wv[3] = st_new;
        trap_valid = 1'b1; trap_cause = cause; trap_pc = pc; trap_tval = tval;
        #1;
        check("trap_ready", {31'h0, trap_ready}, 32'h1);
        tick();
        trap_valid = 1'b0;
        check("trap_busy_inst_ready", {31'h0, inst_ready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("trap_w_enable", {31'h0, csr_w_enable}, 32'h1);
            check("trap_w_addr", {20'h0, csr_w_addr}, {20'h0, wa[i]});
            check("trap_w_val", csr_w_val, wv[i]);
            check("trap_early_redirect", {31'h0, redirect_valid}, 32'h0);
            tick();
        end
        check("trap_vec_wen", {31'h0, csr_w_enable}, 32'h0);
        check("trap_redirect_valid", {31'h0, redirect_valid}, 32'h1);
        check("trap_redirect_pc", redirect_pc, tv & ~32'h3);
        tick();
        check("trap_done_redirect", {31'h0, redirect_valid}, 32'h0);
        check("trap_done_idle", {31'h0, trap_ready}, 32'h1);
        for (int i = 0; i < 4; i++) model[wa[i]] = wv[i];
        $display("trap cause=%08h pc=%08h tval=%08h -> mstatus=%08h redirect=%08h",
                 cause, pc, tval, st_new, tv & ~32'h3);
    endtask

    task automatic do_mret();
        logic [31:0] st, st_new, ep;
        st = model[12'h300];
        ep = model[12'h341];
        st_new = (st & ~32'h1888) | 32'h1880 | ((st & 32'h80) >> 4);
        mret_valid = 1'b1;
        #1;
        check("mret_ready", {31'h0, mret_ready}, 32'h1);
        tick();
        mret_valid = 1'b0;
        check("mret_rd_wen", {31'h0, csr_w_enable}, 32'h0);
        check("mret_rd_redirect", {31'h0, redirect_valid}, 32'h0);
        tick();
        check("mret_w_enable", {31'h0, csr_w_enable}, 32'h1);
        check("mret_w_addr", {20'h0, csr_w_addr}, 32'h300);
        check("mret_w_val", csr_w_val, st_new);
        tick();
        check("mret_vec_wen", {31'h0, csr_w_enable}, 32'h0);
        check("mret_redirect_valid", {31'h0, redirect_valid}, 32'h1);
        check("mret_redirect_pc", redirect_pc, ep);
        tick();
        check("mret_done_redirect", {31'h0, redirect_valid}, 32'h0);
        check("mret_done_idle", {31'h0, trap_ready}, 32'h1);
        model[12'h300] = st_new;
        $display("mret -> mstatus=%08h redirect=%08h", st_new, ep);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_rsp_illegal"}, {31'h0, rsp_illegal}, 32'h0);
        check({tag, "_redirect_valid"}, {31'h0, redirect_valid}, 32'h0);
        check({tag, "_redirect_pc"}, redirect_pc, 32'h0);
        check({tag, "_w_enable"}, {31'h0, csr_w_enable}, 32'h0);
        check({tag, "_w_addr"}, {20'h0, csr_w_addr}, 32'h0);
        check({tag, "_w_val"}, csr_w_val, 32'h0);
        check({tag, "_r_addr"}, {20'h0, csr_r_addr}, 32'h0);
    endtask

    initial begin
        logic [11:0] addr_pool [8];
        logic [11:0] a;
        logic [31:0] src;
        logic        sz;
        int          kind;
        addr_pool[0] = 12'h300; addr_pool[1] = 12'h305; addr_pool[2] = 12'h341;
        addr_pool[3] = 12'h342; addr_pool[4] = 12'h343; addr_pool[5] = 12'h340;
        addr_pool[6] = 12'hF14; addr_pool[7] = 12'hC00;
        for (int i = 0; i < 4096; i++) model[i] = 32'h0;

        rst = 1'b1; mem_clr = 1'b1; preset_en = 1'b0; preset_addr = '0; preset_val = '0;
        inst_valid = 1'b0; inst_op = '0; inst_addr = '0; inst_src = '0; inst_src_zero = 1'b0;
        trap_valid = 1'b0; trap_cause = '0; trap_pc = '0; trap_tval = '0;
        mret_valid = 1'b0;
        repeat (2) tick();
        mem_clr = 1'b0;
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // Read-modify-write, no-write read, illegal cases.
        preset(12'h300, 32'h0000_0008);
        do_inst(3'b010, 12'h300, 32'h80, 1'b0);
        preset(12'h305, 32'h8000_0101);
        do_inst(3'b011, 12'h305, 32'h0, 1'b1);
        do_inst(3'b001, 12'hF14, 32'h1234, 1'b0);
        do_inst(3'b100, 12'h300, 32'h5, 1'b0);
        do_inst(3'b110, 12'hF14, 32'h0, 1'b1);

        // Trap entry.
        preset(12'h300, 32'h0000_0008);
        do_trap(32'h2, 32'h1006, 32'hdead);

        // All three requesters at once: trap, then mret, then the instruction.
        mret_valid = 1'b1;
        inst_valid = 1'b1; inst_op = 3'b010; inst_addr = 12'h340; inst_src = 32'h5; inst_src_zero = 1'b0;
        trap_valid = 1'b1;
        #1;
        check("prio_mret_ready", {31'h0, mret_ready}, 32'h0);
        check("prio_inst_ready", {31'h0, inst_ready}, 32'h0);
        do_trap(32'hb, 32'h2000, 32'h0);
        check("prio2_inst_ready", {31'h0, inst_ready}, 32'h0);
        do_mret();
        do_inst(3'b010, 12'h340, 32'h5, 1'b0);

        // mret from the documented state.
        preset(12'h300, 32'h0000_1880);
        preset(12'h341, 32'h0000_1004);
        do_mret();

        // Reset one cycle into an mret aborts it.
        preset(12'h300, 32'h0000_1880);
        mret_valid = 1'b1;
        tick();
        mret_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        tick();
        check("abort_wen_t2", {31'h0, csr_w_enable}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("abort_wen", {31'h0, csr_w_enable}, 32'h0);
            check("abort_redirect", {31'h0, redirect_valid}, 32'h0);
            tick();
        end
        check("abort_mstatus_kept", regs[12'h300], 32'h0000_1880);
        $display("mret aborted by reset");

        // Random traffic.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                a   = addr_pool[$urandom_range(0, 7)];
                sz  = ($urandom_range(0, 3) == 0);
                src = sz ? 32'h0 : $urandom;
                do_inst(3'($urandom_range(0, 7)), a, src, sz);
            end else if (kind < 8) begin
                do_trap($urandom, $urandom, $urandom);
            end else begin
                do_mret();
            end
        end

        for (int i = 0; i < 6; i++)
            check("final_mem", regs[addr_pool[i]], model[addr_pool[i]]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
# csr_access_ctrl

Sequencer and arbiter in front of `csr_regfile`, which has a single read port and a single write port. It serialises three requesters onto those ports: CSR instructions from execute (read-modify-write), trap entry, and `mret`. It performs the multi-CSR update sequences for trap entry and `mret`, and issues the PC redirect. It is placed between the execute stage and `csr_regfile`; the regfile is unchanged.

## Interface
Parameters: none. CSR addresses and mstatus bit positions are constants from `def.v`.

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- inst_valid  in  1  CSR instruction request
- inst_ready  out  1  request accepted this cycle
- inst_op  in  3  funct3
- inst_addr  in  12  CSR address
- inst_src  in  32  rs1 value, or zero-extended uimm
- inst_src_zero  in  1  rs1 field / uimm == 0
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  old CSR value; 0 if illegal
- rsp_illegal  out  1  illegal-instruction flag, valid with rsp_valid
- trap_valid / trap_ready  in / out  1  trap entry handshake
- trap_cause, trap_pc, trap_tval  in  32  trap payload
- mret_valid / mret_ready  in / out  1  mret handshake
- redirect_valid  out  1  one-cycle pulse
- redirect_pc  out  32  new fetch PC
- csr_r_addr  out  12  to regfile
- csr_r_val  in  32  from regfile
- csr_w_addr  out  12  to regfile
- csr_w_val  out  32  to regfile
- csr_w_enable  out  1  to regfile

## Operation
- **Acceptance and priority**
  - Requests are accepted only in IDLE. Priority is trap > mret > inst.
  - `*_ready` is combinational: state==IDLE and no higher-priority valid is asserted.
  - The payload is latched on acceptance.
- **Instruction path:** IDLE(accept; read inst_addr, latch old value) → INST_WR → IDLE.
  - CSRRW/CSRRWI: new = src.
  - CSRRS/CSRRSI: new = old | src.
  - CSRRC/CSRRCI: new = old & ~src.
  - No write for S/C variants when inst_src_zero=1. RW variants always write.
  - funct3 000 or 100 → illegal.
  - A write to inst_addr[11:10]==2'b11 (read-only space) → illegal.
  - Illegal: no write, rsp_rdata=0.
- **Trap path:** IDLE(accept) → T_EPC → T_CAUSE → T_TVAL → T_STAT → T_VEC → IDLE.
  - T_EPC: write mepc = pc & ~3; read mstatus and latch it.
  - T_CAUSE: write mcause.
  - T_TVAL: write mtval.
  - T_STAT: write mstatus with MPIE=old MIE, MIE=0, MPP=2'b11; all other bits preserved.
  - T_VEC: read mtvec; redirect to mtvec & ~3. Only direct mode is supported.
- **mret path:** IDLE(accept) → M_RD → M_WR → M_VEC → IDLE.
  - M_RD: read mstatus and latch it.
  - M_WR: write mstatus with MIE=MPIE, MPIE=1, MPP=2'b11.
  - M_VEC: read mepc; redirect to mepc.
- **Write timing:** a write never occurs in the same cycle as a read of the same address. This keeps the regfile write-bypass from returning the new value.

## Timing
- **Instruction:** accept at T; at T+1, csr_w_enable (if writing), rsp_valid, rsp_rdata, rsp_illegal. Next acceptance possible at T+2.
- **Trap:** writes at T+1..T+4; redirect_valid at T+5; IDLE at T+6.
- **mret:** mstatus write at T+2; redirect_valid at T+3; IDLE at T+4.
- **Reset (async):** state=IDLE; every registered output is 0.
  - Covers rsp_*, redirect_*, csr_w_enable, csr_w_addr, csr_w_val, csr_r_addr, and all latches.
  - Reset mid-sequence aborts it. No further writes occur and no redirect is issued. CSRs already written keep their values.
- **Simultaneous valids in IDLE:** only the winner sees ready=1. Losers must hold valid.
- **Valids outside IDLE:** ignored while the controller is busy.
- **Held requests:** trap_valid held across completion is accepted again. Upstream must deassert it on redirect.

## Structure
- `def.v` gains:
  - address constants `CSR_MTVEC_ADDR`, `CSR_MEPC_ADDR`, `CSR_MCAUSE_ADDR`, `CSR_MTVAL_ADDR`;
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11;
  - state encodings and funct3 encodings.
- Single module, no sub-module. The mstatus field updates are local functions.

## Test plan
- mstatus=0x00000008; CSRRS 0x300, src=0x80, src_zero=0 → T+1: rsp_rdata=0x00000008; write 0x300←0x00000088.
- CSRRC 0x305, src_zero=1 → rsp_rdata=old mtvec; csr_w_enable=0 for the whole sequence.
- CSRRW 0xF14 → rsp_illegal=1, rsp_rdata=0, no write. funct3=100 → illegal, no write.
- mtvec=0x80000101, mstatus=0x8; trap(cause=2, pc=0x1006, tval=0xdead) → writes mepc=0x1004, mcause=2, mtval=0xdead, mstatus=0x1880; redirect 0x80000100 at T+5.
- trap, mret and inst all valid in the same cycle → trap accepted; mret accepted in the first IDLE cycle after the trap; inst accepted after that.
- mret with mstatus=0x1880, mepc=0x1004 → mstatus←0x1888, redirect 0x1004 at T+3. Reset asserted at T+1 → no write; redirect_valid stays 0.
